// File: rtl/cpu_mem_wb.sv
// Memory-access / write-back stage: performs loads and stores over a req/ack
// data-memory handshake and registers the register-file write port.
module cpu_mem_wb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_reg_write_num,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_num,
  output logic [31:0] reg_write_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        is_load_q, is_load_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] cnt_q, cnt_d;
  logic        misaligned_q, misaligned_d, bus_error_q, bus_error_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_num_q, wb_num_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        mem_op, aligned, accept, fault, timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      is_load_q    <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
      dest_q       <= '0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_num_q     <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      is_load_q    <= is_load_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      dest_q       <= dest_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      wb_en_q      <= wb_en_d;
      wb_num_q     <= wb_num_d;
      wb_data_q    <= wb_data_d;
    end
  end

  always_comb begin
    mem_op = ex_mem_read | ex_mem_write;
    case (ex_mem_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_alu_result[0];
      default: aligned = ~|ex_alu_result[1:0];
    endcase
    accept      = (state_q == IDLE) & ex_valid & mem_op & aligned;
    fault       = (state_q == IDLE) & ex_valid & mem_op & ~aligned;
    timeout_hit = (state_q == ACCESS) & ~dmem_ack & (TIMEOUT != 0) &
                  (cnt_q == 32'(TIMEOUT - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  if (dmem_ack | timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    is_load_d = is_load_q;
    uns_d     = uns_q;
    size_d    = size_q;
    lane_d    = lane_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;

    byte_sel = dmem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase

    if (accept) begin
      req_d     = 1'b1;
      we_d      = ex_mem_write;
      addr_d    = {ex_alu_result[31:2], 2'b00};
      is_load_d = ex_mem_read;
      uns_d     = ex_mem_unsigned;
      size_d    = ex_mem_size;
      lane_d    = ex_alu_result[1:0];
      dest_d    = ex_reg_write_num;
      cnt_d     = '0;
      case (ex_mem_size)
        2'b00: begin
          wdata_d = {4{ex_store_data[7:0]}};
          be_d    = 4'b0001 << ex_alu_result[1:0];
        end
        2'b01: begin
          wdata_d = {2{ex_store_data[15:0]}};
          be_d    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = ex_store_data;
          be_d    = 4'b1111;
        end
      endcase
    end else if (state_q == ACCESS) begin
      if (dmem_ack | timeout_hit) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    misaligned_d = fault;
    bus_error_d  = timeout_hit;

    // Write-back is a pure function of this cycle: anything not retiring drives zeros.
    wb_en_d   = 1'b0;
    wb_num_d  = '0;
    wb_data_d = '0;
    if ((state_q == IDLE) & ex_valid & ~mem_op) begin
      wb_en_d   = ex_reg_write & (ex_reg_write_num != 5'd0);
      wb_num_d  = ex_reg_write_num;
      wb_data_d = ex_alu_result;
    end else if ((state_q == ACCESS) & dmem_ack & is_load_q) begin
      wb_en_d   = dest_q != 5'd0;
      wb_num_d  = dest_q;
      wb_data_d = load_ext;
    end
  end

  assign stall          = accept | ((state_q == ACCESS) & ~dmem_ack & ~timeout_hit);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign misaligned     = misaligned_q;
  assign bus_error      = bus_error_q;
  assign reg_write_en   = wb_en_q;
  assign reg_write_num  = wb_num_q;
  assign reg_write_data = wb_data_q;

endmodule
